// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the lfsr block: default seed, the
// default 8-bit tap mask and a table of maximal-length tap masks.
// Optional build macro LFSR_ZERO_STATE_EN (de Bruijn extension) is
// handled in lfsr_next; nothing here depends on it.
package lfsr_pkg;

    localparam int          LFSR_MIN_WIDTH    = 2;
    localparam int          LFSR_MAX_WIDTH    = 64;
    localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h1;
    localparam logic [7:0]  LFSR_TAPS_8       = 8'hB8;

    // Single tap, numbered from 1 as in the usual polynomial tables.
    function automatic logic [63:0] tap(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Maximal-length tap mask for a given width (bit i set = state bit i
    // feeds the XOR). Returns zero for unsupported widths.
    function automatic logic [63:0] max_taps(input int width);
        case (width)
            2:  return tap(2)  | tap(1);
            3:  return tap(3)  | tap(2);
            4:  return tap(4)  | tap(3);
            5:  return tap(5)  | tap(3);
            6:  return tap(6)  | tap(5);
            7:  return tap(7)  | tap(6);
            8:  return 64'(LFSR_TAPS_8);
            9:  return tap(9)  | tap(5);
            10: return tap(10) | tap(7);
            11: return tap(11) | tap(9);
            12: return tap(12) | tap(6)  | tap(4)  | tap(1);
            13: return tap(13) | tap(4)  | tap(3)  | tap(1);
            14: return tap(14) | tap(5)  | tap(3)  | tap(1);
            15: return tap(15) | tap(14);
            16: return tap(16) | tap(15) | tap(13) | tap(4);
            17: return tap(17) | tap(14);
            18: return tap(18) | tap(11);
            19: return tap(19) | tap(6)  | tap(2)  | tap(1);
            20: return tap(20) | tap(17);
            21: return tap(21) | tap(19);
            22: return tap(22) | tap(21);
            23: return tap(23) | tap(18);
            24: return tap(24) | tap(23) | tap(22) | tap(17);
            25: return tap(25) | tap(22);
            26: return tap(26) | tap(6)  | tap(2)  | tap(1);
            27: return tap(27) | tap(5)  | tap(2)  | tap(1);
            28: return tap(28) | tap(25);
            29: return tap(29) | tap(27);
            30: return tap(30) | tap(6)  | tap(4)  | tap(1);
            31: return tap(31) | tap(28);
            32: return tap(32) | tap(22) | tap(2)  | tap(1);
            33: return tap(33) | tap(20);
            34: return tap(34) | tap(27) | tap(2)  | tap(1);
            35: return tap(35) | tap(33);
            36: return tap(36) | tap(25);
            37: return tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
            38: return tap(38) | tap(6)  | tap(5)  | tap(1);
            39: return tap(39) | tap(35);
            40: return tap(40) | tap(38) | tap(21) | tap(19);
            41: return tap(41) | tap(38);
            42: return tap(42) | tap(41) | tap(20) | tap(19);
            43: return tap(43) | tap(42) | tap(38) | tap(37);
            44: return tap(44) | tap(43) | tap(18) | tap(17);
            45: return tap(45) | tap(44) | tap(42) | tap(41);
            46: return tap(46) | tap(45) | tap(26) | tap(25);
            47: return tap(47) | tap(42);
            48: return tap(48) | tap(47) | tap(21) | tap(20);
            49: return tap(49) | tap(40);
            50: return tap(50) | tap(49) | tap(24) | tap(23);
            51: return tap(51) | tap(50) | tap(36) | tap(35);
            52: return tap(52) | tap(49);
            53: return tap(53) | tap(52) | tap(38) | tap(37);
            54: return tap(54) | tap(53) | tap(18) | tap(17);
            55: return tap(55) | tap(31);
            56: return tap(56) | tap(55) | tap(35) | tap(34);
            57: return tap(57) | tap(50);
            58: return tap(58) | tap(39);
            59: return tap(59) | tap(58) | tap(38) | tap(37);
            60: return tap(60) | tap(59);
            61: return tap(61) | tap(60) | tap(46) | tap(45);
            62: return tap(62) | tap(61) | tap(6)  | tap(5);
            63: return tap(63) | tap(62);
            64: return tap(64) | tap(63) | tap(61) | tap(60);
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Next-state function of the Fibonacci LFSR: shift left, feedback into
// bit 0. With LFSR_ZERO_STATE_EN defined, the feedback also inverts when
// all bits below the MSB are zero, splicing the all-zero state in between
// 100..0 and 00..1 (de Bruijn sequence, period 2^WIDTH).
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(max_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic fb;

    // Feedback XOR over the tapped bits, then shift it in at the bottom.
    always_comb begin
        fb = ^(state & TAPS);
`ifdef LFSR_ZERO_STATE_EN
        fb = fb ^ (state[WIDTH-2:0] == '0);
`endif
        next_state = {state[WIDTH-2:0], fb};
    end

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR: holds the state register, async reset to
// SEED and the step enable; the feedback lives in lfsr_next.
// Optional build macro LFSR_ZERO_STATE_EN: de Bruijn extension that makes
// the all-zero state part of the sequence and allows SEED == 0.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(max_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "lfsr: WIDTH must be in 2..64");
    end

    if (!TAPS[WIDTH-1]) begin : g_bad_taps
        $fatal(1, "lfsr: TAPS must include the MSB");
    end

`ifndef LFSR_ZERO_STATE_EN
    // Zero is a lock-up state without the de Bruijn term.
    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr: SEED must be non-zero");
    end
`endif

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state      (state),
        .next_state (next_state)
    );

    // Async load of SEED on reset; otherwise advance on enabled clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (enable) begin
            state <= next_state;
        end
    end

    assign value = state;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: default 8-bit instance plus a 4-bit instance
// (TAPS 4'hC, SEED 4'h1). Expectations follow LFSR_ZERO_STATE_EN if the
// bench is built with it.
module tb_lfsr;

`ifdef LFSR_ZERO_STATE_EN
    localparam int         PERIOD8  = 256;
    localparam int         PERIOD4  = 16;
    localparam logic [7:0] AFTER_80 = 8'h00;
    localparam bit         ZERO_OK  = 1'b1;
`else
    localparam int         PERIOD8  = 255;
    localparam int         PERIOD4  = 15;
    localparam logic [7:0] AFTER_80 = 8'h01;
    localparam bit         ZERO_OK  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] value;
    logic [3:0] value4;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr u_dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .value  (value)
    );

    lfsr #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .SEED  (4'h1)
    ) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .value  (value4)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        #1;
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if (value !== 8'h01) begin
                n_fail++;
                $display("FAIL reset_hold8: got %h want 01", value);
            end
            n_checks++;
            if (value4 !== 4'h1) begin
                n_fail++;
                $display("FAIL reset_hold4: got %h want 1", value4);
            end
        end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (value !== exp_seq[0]) begin
            n_fail++;
            $display("FAIL seq[0]: got %h want %h", value, exp_seq[0]);
        end
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (value !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL seq[%0d]: got %h want %h", i, value, exp_seq[i]);
            end
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (value !== 8'h01) begin
            n_fail++;
            $display("FAIL midrun_async: got %h want 01", value);
        end
        @(posedge clk); #1;
        n_checks++;
        if (value !== 8'h01) begin
            n_fail++;
            $display("FAIL midrun_held: got %h want 01", value);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (value !== 8'h02) begin
            n_fail++;
            $display("FAIL midrun_restart: got %h want 02", value);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h04, 8'h08, 8'h11, 8'h23};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (value !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL hold_pre[%0d]: got %h want %h", i, value, exp_seq[i]);
            end
        end
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (value !== 8'h23) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h want 23", i, value);
            end
        end
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (value !== 8'h47) begin
            n_fail++;
            $display("FAIL hold_resume: got %h want 47", value);
        end
    endtask

    task automatic test_period8();
        bit         seen [256];
        int         steps    = 0;
        int         dups     = 0;
        int         distinct = 1;
        bit         zero_seen = 1'b0;
        bit         done     = 1'b0;
        logic [7:0] prev;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        prev = 8'h01;
        while (!done && steps < 300) begin
            @(posedge clk); #1;
            steps++;
            if (prev == 8'h80) begin
                n_checks++;
                if (value !== AFTER_80) begin
                    n_fail++;
                    $display("FAIL after_80: got %h want %h", value, AFTER_80);
                end
            end
            if (value == 8'h00) zero_seen = 1'b1;
            if (value == 8'h01) begin
                done = 1'b1;
            end else begin
                if (seen[value]) dups++;
                else distinct++;
                seen[value] = 1'b1;
            end
            prev = value;
        end
        n_checks++;
        if (steps != PERIOD8) begin
            n_fail++;
            $display("FAIL period8: got %0d steps want %0d", steps, PERIOD8);
        end
        n_checks++;
        if (distinct != PERIOD8 || dups != 0) begin
            n_fail++;
            $display("FAIL distinct8: got %0d distinct %0d dups want %0d 0", distinct, dups, PERIOD8);
        end
        n_checks++;
        if (zero_seen != ZERO_OK) begin
            n_fail++;
            $display("FAIL zero8: got %0b want %0b", zero_seen, ZERO_OK);
        end
    endtask

    task automatic test_width4();
        logic [3:0] exp_seq [7];
        bit         seen [16];
        int         steps    = 0;
        int         dups     = 0;
        int         distinct = 1;
        bit         zero_seen = 1'b0;
        bit         done     = 1'b0;
        exp_seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        while (!done && steps < 40) begin
            @(posedge clk); #1;
            if (steps < 7) begin
                n_checks++;
                if (value4 !== exp_seq[steps]) begin
                    n_fail++;
                    $display("FAIL seq4[%0d]: got %h want %h", steps, value4, exp_seq[steps]);
                end
            end
            steps++;
            if (value4 == 4'h0) zero_seen = 1'b1;
            if (value4 == 4'h1) begin
                done = 1'b1;
            end else begin
                if (seen[value4]) dups++;
                else distinct++;
                seen[value4] = 1'b1;
            end
        end
        n_checks++;
        if (steps != PERIOD4) begin
            n_fail++;
            $display("FAIL period4: got %0d steps want %0d", steps, PERIOD4);
        end
        n_checks++;
        if (distinct != PERIOD4 || dups != 0) begin
            n_fail++;
            $display("FAIL distinct4: got %0d distinct %0d dups want %0d 0", distinct, dups, PERIOD4);
        end
        n_checks++;
        if (zero_seen != ZERO_OK) begin
            n_fail++;
            $display("FAIL zero4: got %0b want %0b", zero_seen, ZERO_OK);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_midrun_reset();
        test_hold();
        test_period8();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
